// File: rtl/voxel_seq_pkg.sv
// voxel_seq_pkg: shared state encoding, camera register types and indices
package voxel_seq_pkg;

    typedef enum logic [2:0] {
        RESET_WAIT = 3'd0,
        WORLD      = 3'd1,
        READY      = 3'd2,
        LAUNCH     = 3'd3,
        RUN        = 3'd4,
        GAP        = 3'd5
    } seq_state_t;

    typedef logic [15:0] cam_reg_t;

    localparam int CAM_POS_X = 0;
    localparam int CAM_POS_Y = 1;
    localparam int CAM_POS_Z = 2;
    localparam int CAM_YAW   = 3;
    localparam int CAM_PITCH = 4;
    localparam int CAM_FOV   = 5;
    localparam int CAM_NEAR  = 6;
    localparam int CAM_FAR   = 7;

    // Framebuffer index width, never narrower than one bit
    function automatic int fb_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voxel_cam_bank.sv
// voxel_cam_bank: host-writable shadow camera registers and the per-frame frozen copy
module voxel_cam_bank
    import voxel_seq_pkg::*;
#(
    parameter int CAM_REGS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [3:0]              i_wr_idx,
    input  cam_reg_t                i_wr_data,
    input  logic                    i_load,
    output logic [16*CAM_REGS-1:0]  o_active
);

    logic [16*CAM_REGS-1:0] r_shadow;
    logic [16*CAM_REGS-1:0] r_active;

    // Host writes land in the shadow bank at once; out-of-range indices match no register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else begin
            for (int i = 0; i < CAM_REGS; i++) begin
                if (i_wr_en && int'(i_wr_idx) == i) r_shadow[16*i +: 16] <= i_wr_data;
            end
        end
    end

    // Freeze the whole shadow bank for the frame being launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_active <= '0;
        else if (i_load) r_active <= r_shadow;
    end

    assign o_active = r_active;

endmodule

// File: rtl/voxel_frame_sequencer.sv
// voxel_frame_sequencer: world build / frame launch sequencing with framebuffer rotation
// Optional frame watchdog enabled by defining VOXEL_SEQ_WATCHDOG_EN.
module voxel_frame_sequencer
    import voxel_seq_pkg::*;
#(
    parameter int NUM_FB     = 2,
    parameter int CAM_REGS   = 8,
    parameter int GAP_CYCLES = 4,
    parameter int WDT_CYCLES = 1 << 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_host_wr_en,
    input  logic [3:0]                     i_host_wr_idx,
    input  cam_reg_t                       i_host_wr_data,
    input  logic                           i_ctrl_run,
    input  logic                           i_ctrl_step,
    input  logic                           i_ctrl_regen,
    output logic                           o_world_start,
    input  logic                           i_world_done,
    output logic                           o_core_start,
    input  logic                           i_core_busy,
    input  logic                           i_core_done,
    output logic [16*CAM_REGS-1:0]         o_cam_active,
    output logic [fb_width(NUM_FB)-1:0]    o_fb_sel,
    output logic [fb_width(NUM_FB)-1:0]    o_fb_disp,
    output logic [31:0]                    o_frame_count,
    output logic                           o_frame_done,
    output logic                           o_world_ready,
    output logic [2:0]                     o_state,
    output logic                           o_wdt_flag
);

    localparam int FB_W = fb_width(NUM_FB);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic              r_step;
    logic              r_regen;
    logic              r_world_start;
    logic              r_core_start;
    logic              r_frame_done;
    logic              r_world_ready;
    logic [FB_W-1:0]   r_fb_sel;
    logic [FB_W-1:0]   r_fb_disp;
    logic [31:0]       r_frame_count;
    logic [7:0]        r_gap_cnt;
    logic              w_launch;
    logic              w_regen_go;
    logic              w_frame_end;
    logic              w_gap_end;
    logic              w_wdt_hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RESET_WAIT;
        else r_state <= w_next;
    end

    // Next-state logic; a pending regen outranks a launch in READY
    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET_WAIT: w_next = WORLD;
            WORLD:      w_next = i_world_done ? READY : WORLD;
            READY:      w_next = w_regen_go ? WORLD : (w_launch ? LAUNCH : READY);
            LAUNCH:     w_next = RUN;
            RUN:        w_next = w_frame_end ? ((GAP_CYCLES == 0) ? READY : GAP)
                                             : (w_wdt_hit ? READY : RUN);
            GAP:        w_next = w_gap_end ? READY : GAP;
            default:    w_next = RESET_WAIT;
        endcase
    end

    // Decoded events that drive the registered outputs and datapath
    always_comb begin
        w_regen_go  = (r_state == READY) && r_regen;
        w_launch    = (r_state == READY) && !r_regen && (i_ctrl_run || r_step) && !i_core_busy;
        w_frame_end = (r_state == RUN) && i_core_done;
        w_gap_end   = (r_state == GAP) && (r_gap_cnt == 8'(GAP_CYCLES - 1));
    end

    // Registered pulses, pending requests, gap timer and framebuffer bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_world_start <= 1'b0;
            r_core_start  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_world_ready <= 1'b0;
            r_step        <= 1'b0;
            r_regen       <= 1'b0;
            r_gap_cnt     <= 8'd0;
            r_fb_sel      <= '0;
            r_fb_disp     <= '0;
            r_frame_count <= 32'd0;
        end else begin
            r_world_start <= (r_state == RESET_WAIT) || w_regen_go;
            r_core_start  <= w_launch;
            r_frame_done  <= w_frame_end;
            r_world_ready <= (r_state == WORLD && i_world_done) ? 1'b1
                           : (w_regen_go ? 1'b0 : r_world_ready);
            r_step        <= (r_step || i_ctrl_step) && !w_launch;
            r_regen       <= (r_regen || i_ctrl_regen) && !w_regen_go;
            r_gap_cnt     <= (r_state == GAP) ? r_gap_cnt + 8'd1 : 8'd0;
            if (w_frame_end) begin
                r_fb_disp     <= r_fb_sel;
                r_fb_sel      <= (r_fb_sel == FB_W'(NUM_FB - 1)) ? '0 : r_fb_sel + 1'b1;
                r_frame_count <= r_frame_count + 32'd1;
            end
        end
    end

`ifdef VOXEL_SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt_flag;

    assign w_wdt_hit = (r_state == RUN) && !i_core_done && (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    // Count cycles spent in RUN; a timeout abandons the frame and latches the flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt_cnt  <= '0;
            r_wdt_flag <= 1'b0;
        end else begin
            r_wdt_cnt  <= (r_state == RUN) ? r_wdt_cnt + 1'b1 : '0;
            r_wdt_flag <= r_wdt_flag || w_wdt_hit;
        end
    end

    assign o_wdt_flag = r_wdt_flag;
`else
    assign w_wdt_hit  = 1'b0;
    assign o_wdt_flag = 1'b0;
`endif

    voxel_cam_bank #(
        .CAM_REGS (CAM_REGS)
    ) u_cam_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (i_host_wr_en),
        .i_wr_idx  (i_host_wr_idx),
        .i_wr_data (i_host_wr_data),
        .i_load    (w_launch),
        .o_active  (o_cam_active)
    );

    assign o_world_start = r_world_start;
    assign o_core_start  = r_core_start;
    assign o_frame_done  = r_frame_done;
    assign o_world_ready = r_world_ready;
    assign o_fb_sel      = r_fb_sel;
    assign o_fb_disp     = r_fb_disp;
    assign o_frame_count = r_frame_count;
    assign o_state       = r_state;

endmodule

// File: tb/tb_voxel_frame_sequencer.sv
// tb_voxel_frame_sequencer: directed self-checking bench for voxel_frame_sequencer
module tb_voxel_frame_sequencer;
    import voxel_seq_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_wr_en = 1'b0;
    logic [3:0]    host_wr_idx = 4'd0;
    logic [15:0]   host_wr_data = 16'd0;
    logic          ctrl_run = 1'b0;
    logic          ctrl_step = 1'b0;
    logic          ctrl_regen = 1'b0;
    logic          world_done = 1'b0;
    logic          core_busy = 1'b0;
    logic          core_done = 1'b0;
    logic          world_start;
    logic          core_start;
    logic [127:0]  cam_active;
    logic [1:0]    fb_sel;
    logic [1:0]    fb_disp;
    logic [31:0]   frame_count;
    logic          frame_done;
    logic          world_ready;
    logic [2:0]    state_o;
    logic          wdt_flag;

    int vectors = 0;
    int miscompares = 0;
    int n_fd = 0;

    voxel_frame_sequencer #(
        .NUM_FB     (3),
        .CAM_REGS   (8),
        .GAP_CYCLES (2),
        .WDT_CYCLES (100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_host_wr_en   (host_wr_en),
        .i_host_wr_idx  (host_wr_idx),
        .i_host_wr_data (host_wr_data),
        .i_ctrl_run     (ctrl_run),
        .i_ctrl_step    (ctrl_step),
        .i_ctrl_regen   (ctrl_regen),
        .o_world_start  (world_start),
        .i_world_done   (world_done),
        .o_core_start   (core_start),
        .i_core_busy    (core_busy),
        .i_core_done    (core_done),
        .o_cam_active   (cam_active),
        .o_fb_sel       (fb_sel),
        .o_fb_disp      (fb_disp),
        .o_frame_count  (frame_count),
        .o_frame_done   (frame_done),
        .o_world_ready  (world_ready),
        .o_state        (state_o),
        .o_wdt_flag     (wdt_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) n_fd++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 128'(state_o), 128'(s));
    endtask

    task automatic frame(input logic [1:0] d, input logic [1:0] s, input logic [31:0] c);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("frame_state", 128'(state_o), 128'(GAP));
        chk("frame_done", 128'(frame_done), 128'(1));
        chk("fb_disp", 128'(fb_disp), 128'(d));
        chk("fb_sel", 128'(fb_sel), 128'(s));
        chk("frame_count", 128'(frame_count), 128'(c));
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_state", 128'(state_o), 128'(RESET_WAIT));
        chk("rst_world_ready", 128'(world_ready), 128'(0));
        chk("rst_pulses", 128'({world_start, core_start, frame_done}), 128'(0));
        chk("rst_fb", 128'({fb_sel, fb_disp}), 128'(0));
        chk("rst_count", 128'(frame_count), 128'(0));
        chk("rst_cam", cam_active, 128'(0));
        chk("rst_wdt", 128'(wdt_flag), 128'(0));

        rst_n = 1'b1;
        ctrl_run = 1'b1;
        tick();
        chk("ws_state", 128'(state_o), 128'(WORLD));
        chk("ws_pulse", 128'(world_start), 128'(1));
        host_wr_en = 1'b1; host_wr_idx = 4'd1; host_wr_data = 16'h1234;
        tick();
        chk("ws_once", 128'(world_start), 128'(0));
        host_wr_idx = 4'd9; host_wr_data = 16'hBEEF;
        tick();
        host_wr_en = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_in_world_state", 128'(state_o), 128'(WORLD));
        chk("done_in_world_cnt", 128'(frame_count), 128'(0));
        repeat (5) tick();
        world_done = 1'b1;
        tick();
        world_done = 1'b0;
        chk("ready_state", 128'(state_o), 128'(READY));
        chk("world_ready", 128'(world_ready), 128'(1));
        chk("no_early_core_start", 128'(core_start), 128'(0));
        tick();
        chk("launch_state", 128'(state_o), 128'(LAUNCH));
        chk("core_start", 128'(core_start), 128'(1));
        chk("cam_first", cam_active, {96'd0, 16'h1234, 16'h0000});
        tick();
        chk("run_state", 128'(state_o), 128'(RUN));
        chk("core_start_once", 128'(core_start), 128'(0));

        host_wr_en = 1'b1; host_wr_idx = 4'd0; host_wr_data = 16'h0A00;
        tick();
        host_wr_en = 1'b0;
        chk("cam_hold_in_run", cam_active, {96'd0, 16'h1234, 16'h0000});
        world_done = 1'b1;
        tick();
        world_done = 1'b0;
        chk("world_done_in_run", 128'(state_o), 128'(RUN));
        frame(2'd0, 2'd1, 32'd1);
        tick();
        chk("frame_done_once", 128'(frame_done), 128'(0));
        chk("gap_hold", 128'(state_o), 128'(GAP));
        tick();
        chk("gap_to_ready", 128'(state_o), 128'(READY));
        tick();
        chk("launch2", 128'(state_o), 128'(LAUNCH));
        chk("cam_second", cam_active, {96'd0, 16'h1234, 16'h0A00});
        wait_state(RUN, 4, "run2");
        frame(2'd1, 2'd2, 32'd2);
        wait_state(RUN, 8, "run3");
        frame(2'd2, 2'd0, 32'd3);
        wait_state(RUN, 8, "run4");
        ctrl_run = 1'b0;
        frame(2'd0, 2'd1, 32'd4);
        wait_state(READY, 8, "idle_ready");
        repeat (4) tick();
        chk("idle_hold", 128'(state_o), 128'(READY));
        chk("idle_no_start", 128'(core_start), 128'(0));
        chk("fd_pulses4", 128'(n_fd), 128'(4));

        ctrl_step = 1'b1;
        tick();
        ctrl_step = 1'b0;
        tick();
        chk("step_launch", 128'(state_o), 128'(LAUNCH));
        chk("step_core_start", 128'(core_start), 128'(1));
        tick();
        repeat (2) begin
            ctrl_step = 1'b1;
            tick();
            ctrl_step = 1'b0;
            tick();
        end
        frame(2'd1, 2'd2, 32'd5);
        wait_state(LAUNCH, 8, "step_collapse_launch");
        tick();
        frame(2'd2, 2'd0, 32'd6);
        repeat (8) tick();
        chk("step_idle", 128'(state_o), 128'(READY));
        chk("step_count", 128'(frame_count), 128'(6));

        ctrl_step = 1'b1;
        tick();
        ctrl_step = 1'b0;
        wait_state(RUN, 5, "regen_run");
        ctrl_regen = 1'b1;
        tick();
        ctrl_regen = 1'b0;
        tick();
        chk("regen_frame_continues", 128'(state_o), 128'(RUN));
        frame(2'd0, 2'd1, 32'd7);
        wait_state(WORLD, 10, "regen_world");
        chk("regen_world_start", 128'(world_start), 128'(1));
        chk("regen_not_ready", 128'(world_ready), 128'(0));
        repeat (3) tick();
        chk("regen_wait_world", 128'(state_o), 128'(WORLD));
        chk("regen_still_not_ready", 128'(world_ready), 128'(0));

        ctrl_regen = 1'b1;
        tick();
        ctrl_regen = 1'b0;
        ctrl_run = 1'b1;
        world_done = 1'b1;
        tick();
        world_done = 1'b0;
        chk("prio_ready", 128'(state_o), 128'(READY));
        chk("prio_world_ready", 128'(world_ready), 128'(1));
        tick();
        chk("prio_regen_first", 128'(state_o), 128'(WORLD));
        chk("prio_no_core_start", 128'(core_start), 128'(0));
        chk("prio_world_start", 128'(world_start), 128'(1));
        world_done = 1'b1;
        tick();
        world_done = 1'b0;
        tick();
        chk("prio_then_launch", 128'(core_start), 128'(1));
        tick();
        chk("wdt_run_entry", 128'(state_o), 128'(RUN));

`ifdef VOXEL_SEQ_WATCHDOG_EN
        repeat (99) tick();
        chk("wdt_before", 128'({state_o, wdt_flag}), 128'({RUN, 1'b0}));
        ctrl_run = 1'b0;
        tick();
        chk("wdt_state", 128'(state_o), 128'(READY));
        chk("wdt_flag", 128'(wdt_flag), 128'(1));
        chk("wdt_count", 128'(frame_count), 128'(7));
        chk("wdt_fb", 128'({fb_sel, fb_disp}), 128'({2'd1, 2'd0}));
        repeat (3) tick();
        chk("wdt_sticky", 128'(wdt_flag), 128'(1));
        ctrl_step = 1'b1;
        tick();
        ctrl_step = 1'b0;
        wait_state(RUN, 5, "wdt_rerun");
`else
        repeat (150) tick();
        chk("nowdt_state", 128'(state_o), 128'(RUN));
        chk("nowdt_flag", 128'(wdt_flag), 128'(0));
`endif

        #3;
        rst_n = 1'b0;
        core_done = 1'b1;
        #1;
        chk("midrst_state", 128'(state_o), 128'(RESET_WAIT));
        chk("midrst_count", 128'(frame_count), 128'(0));
        chk("midrst_fb", 128'({fb_sel, fb_disp}), 128'(0));
        chk("midrst_cam", cam_active, 128'(0));
        chk("midrst_flags", 128'({world_ready, wdt_flag, core_start}), 128'(0));
        tick();
        core_done = 1'b0;
        tick();
        chk("midrst_no_done", 128'(frame_done), 128'(0));
        chk("fd_pulses7", 128'(n_fd), 128'(7));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
